// File: rtl/axi_full_pkg.sv
// Shared AXI response codes, burst encodings and FSM state types for the
// full-AXI memory slave.
package axi_full_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Encodings are ordered so the numerically larger code is the more severe one.
  function automatic resp_t worst_resp(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address and burst legality for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import axi_full_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  legal
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    aligned   = addr & ~(step - ADDR_WIDTH'(1));
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = addr;
    legal     = 1'b1;
    case (burst_t'(burst))
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = aligned + step;
      BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);
        legal     = len inside {8'd1, 8'd3, 8'd7, 8'd15};
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_full_mem_slave.sv
// AXI4 memory slave: independent single-outstanding write and read FSMs over
// one byte-enabled, synchronously read storage array.
module axi_full_mem_slave
  import axi_full_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0]            SIZE      = 3'(ADDR_LSB);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

  // Offset below the base wraps into the extra top bit and fails the compare.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, MEM_BASE};
    return off < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  ready_en_q;

  // ---------------- write path ----------------
  wstate_t               wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0] waddr_q, wnext;
  logic [7:0]            wlen_q, wcnt_q;
  logic [1:0]            wburst_q;
  logic [ID_WIDTH-1:0]   bid_q;
  resp_t                 bresp_q, w_beat_resp;
  logic                  wlegal, w_beat, w_final, w_inwin, w_store;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
    .addr(waddr_q), .len(wlen_q), .burst(wburst_q), .size(SIZE),
    .next_addr(wnext), .legal(wlegal)
  );

  always_comb begin
    w_beat      = (wstate_q == W_DATA) && wvalid;
    w_final     = (wcnt_q == wlen_q);
    w_inwin     = in_window(waddr_q);
    w_store     = w_beat && w_inwin && wlegal;
    w_beat_resp = !w_inwin ? RESP_DECERR :
                  (!wlegal || (wlast != w_final)) ? RESP_SLVERR : RESP_OKAY;
  end

  always_comb begin
    wstate_d = wstate_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready = ready_en_q;
        if (awvalid && ready_en_q) wstate_d = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) wstate_d = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      wstate_q   <= W_IDLE;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      wburst_q   <= '0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      wstate_q   <= wstate_d;
      if (awready && awvalid) begin
        waddr_q  <= awaddr;
        wlen_q   <= awlen;
        wburst_q <= awburst;
        wcnt_q   <= '0;
        bid_q    <= awid;
        bresp_q  <= RESP_OKAY;
      end
      if (w_beat) begin
        waddr_q <= wnext;
        wcnt_q  <= wcnt_q + 8'd1;
        bresp_q <= worst_resp(bresp_q, w_beat_resp);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_store) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign bid   = bid_q;
  assign bresp = bresp_q;

  // ---------------- read path ----------------
  rstate_t               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] raddr_q, rnext, g_addr, load_addr;
  logic [7:0]            rlen_q, rcnt_q, g_len;
  logic [1:0]            rburst_q, g_burst;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;
  logic                  rlast_q, rlegal, ar_hs, r_hs, r_load, load_inwin;

  // While idle the generator evaluates the incoming AR request so the first
  // beat can be fetched on the handshake edge itself.
  always_comb begin
    g_addr     = (rstate_q == R_IDLE) ? araddr  : raddr_q;
    g_len      = (rstate_q == R_IDLE) ? arlen   : rlen_q;
    g_burst    = (rstate_q == R_IDLE) ? arburst : rburst_q;
    load_addr  = (rstate_q == R_IDLE) ? araddr  : rnext;
    load_inwin = in_window(load_addr);
    ar_hs      = arready && arvalid;
    r_hs       = rvalid && rready;
    r_load     = ar_hs || (r_hs && !rlast_q);
  end

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
    .addr(g_addr), .len(g_len), .burst(g_burst), .size(SIZE),
    .next_addr(rnext), .legal(rlegal)
  );

  always_comb begin
    rstate_d = rstate_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = ready_en_q;
        if (arvalid && ready_en_q) rstate_d = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast_q) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rburst_q <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        raddr_q  <= araddr;
        rlen_q   <= arlen;
        rburst_q <= arburst;
        rcnt_q   <= '0;
        rid_q    <= arid;
        rlast_q  <= (arlen == 8'd0);
      end else if (r_hs && !rlast_q) begin
        raddr_q <= rnext;
        rcnt_q  <= rcnt_q + 8'd1;
        rlast_q <= (rcnt_q + 8'd1 == rlen_q);
      end else if (r_hs) begin
        rlast_q <= 1'b0;
      end
      if (r_load) begin
        rdata_q <= (load_inwin && rlegal) ? mem[word_idx(load_addr)] : '0;
        rresp_q <= !load_inwin ? RESP_DECERR : (!rlegal ? RESP_SLVERR : RESP_OKAY);
      end
    end
  end

  assign rid   = rid_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rlast_q;

endmodule
